// File: rtl/fetch_unit.sv
// fetch_unit: walks the PC through instruction memory and assembles one- or
// two-word instructions into the IR, honouring stall and redirect requests.
module fetch_unit #(
  parameter int PC_WIDTH = 20,
  parameter int RESET_PC = 0,
  parameter int IMM_BIT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  output logic                ir_we,
  output logic [15:0]         ir_data,
  output logic [15:0]         imm_data,
  output logic                imm_valid,
  output logic [PC_WIDTH-1:0] inst_pc,
  output logic [PC_WIDTH-1:0] pc
);
  typedef enum logic {FETCH, FETCH_IMM} state_t;
  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next, pending_pc;
  logic [15:0]         pending;
  logic                we_next, capture;
  assign imem_addr = pc;
  always_comb begin
    state_next = state;
    pc_next    = pc;
    we_next    = 1'b0;
    capture    = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_pc;
      state_next = FETCH;
    end else if (!stall) begin
      pc_next = pc + PC_WIDTH'(1);
      if (state == FETCH_IMM) begin
        state_next = FETCH;
        we_next    = 1'b1;
      end else if (imem_data[IMM_BIT]) begin
        state_next = FETCH_IMM;
        capture    = 1'b1;
      end else begin
        we_next = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FETCH;
      pc         <= PC_WIDTH'(RESET_PC);
      pending    <= '0;
      pending_pc <= '0;
      ir_we      <= 1'b0;
      ir_data    <= '0;
      imm_data   <= '0;
      imm_valid  <= 1'b0;
      inst_pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir_we <= we_next;
      if (capture) begin
        pending    <= imem_data;
        pending_pc <= pc;
      end
      if (we_next) begin
        ir_data   <= (state == FETCH_IMM) ? pending : imem_data;
        imm_data  <= (state == FETCH_IMM) ? imem_data : 16'h0;
        imm_valid <= (state == FETCH_IMM);
        inst_pc   <= (state == FETCH_IMM) ? pending_pc : pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an
// instruction-level reference model.
module tb_fetch_unit;
  logic        clk = 0, rst = 0, stall = 0, redirect_valid = 0;
  logic [19:0] redirect_pc = '0;
  logic [19:0] imem_addr, inst_pc, pc;
  logic [15:0] imem_data, ir_data, imm_data;
  logic        ir_we, imm_valid;
  logic [15:0] mem [0:4095];
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[11:0]];

  fetch_unit #(.PC_WIDTH(20), .RESET_PC(0), .IMM_BIT(0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir_we(ir_we), .ir_data(ir_data), .imm_data(imm_data), .imm_valid(imm_valid),
    .inst_pc(inst_pc), .pc(pc)
  );

  // narrow instance for PC wrap: every word is a one-word instruction
  logic        rst4 = 0;
  logic [3:0]  addr4, inst_pc4, pc4;
  logic [15:0] ir4, imm4;
  logic        we4, iv4;
  fetch_unit #(.PC_WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(4'd0), .imem_addr(addr4), .imem_data({8'h00, addr4, 4'h0}),
    .ir_we(we4), .ir_data(ir4), .imm_data(imm4), .imm_valid(iv4),
    .inst_pc(inst_pc4), .pc(pc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: instruction-level view of the fetch stream
  logic [19:0] m_pc = '0, m_opc = '0, e_ipc = '0;
  logic [15:0] m_op = '0, e_ir = '0, e_imm = '0, w;
  logic        m_has = 0, e_we = 0, e_iv = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = '0; m_has = 0; m_op = '0; m_opc = '0;
      e_we = 0; e_ir = '0; e_imm = '0; e_iv = 0; e_ipc = '0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_has = 0; e_we = 0;
    end else if (stall) begin
      e_we = 0;
    end else begin
      w = mem[m_pc[11:0]];
      if (m_has) begin
        e_ir = m_op; e_imm = w; e_iv = 1; e_ipc = m_opc; e_we = 1; m_has = 0;
      end else if (w[0]) begin
        m_op = w; m_opc = m_pc; m_has = 1; e_we = 0;
      end else begin
        e_ir = w; e_imm = '0; e_iv = 0; e_ipc = m_pc; e_we = 1;
      end
      m_pc = m_pc + 20'd1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("ir_we", ir_we, e_we);
      chk("ir_data", ir_data, e_ir);
      chk("imm_data", imm_data, e_imm);
      chk("imm_valid", imm_valid, e_iv);
      chk("inst_pc", inst_pc, e_ipc);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst4 = 1;
    repeat (16) @(negedge clk);
    chk("wrap4_inst_pc", inst_pc4, 4'hF);
    chk("wrap4_pc", pc4, 4'h0);
    chk("wrap4_ir", ir4, 16'h00F0);
    chk("wrap4_we", we4, 1'b1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    mem[0] = 16'h1234; mem[1] = 16'h4321; mem[2] = 16'h270F;
    mem[3] = 16'h5551; mem[12'h100] = 16'hABC0; mem[12'h101] = 16'h7771;
    repeat (2) step();
    chk("rst_pc", pc, 0);
    chk("rst_we", ir_we, 0);
    chk("rst_ir", ir_data, 0);
    rst = 1;
    step();
    chk("w1_we", ir_we, 1); chk("w1_ir", ir_data, 16'h1234);
    chk("w1_iv", imm_valid, 0); chk("w1_ipc", inst_pc, 0); chk("w1_pc", pc, 1);
    step();
    chk("w2a_we", ir_we, 0); chk("w2a_pc", pc, 2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 2); chk("stall_we", ir_we, 0); chk("stall_ir", ir_data, 16'h1234);
    end
    stall = 0;
    step();
    chk("w2_we", ir_we, 1); chk("w2_ir", ir_data, 16'h4321); chk("w2_imm", imm_data, 16'h270F);
    chk("w2_iv", imm_valid, 1); chk("w2_ipc", inst_pc, 1); chk("w2_pc", pc, 3);
    step();
    chk("fi_pc", pc, 4); chk("fi_we", ir_we, 0);
    redirect_valid = 1; redirect_pc = 20'h00100; stall = 1;
    step();
    chk("rd_pc", pc, 20'h00100); chk("rd_we", ir_we, 0); chk("rd_ir", ir_data, 16'h4321);
    redirect_valid = 0; stall = 0;
    step();
    chk("rd2_we", ir_we, 1); chk("rd2_ir", ir_data, 16'hABC0);
    chk("rd2_ipc", inst_pc, 20'h00100); chk("rd2_pc", pc, 20'h00101);
    step();
    chk("ar_pre_pc", pc, 20'h00102);
    #2 rst = 0;
    #1;
    chk("ar_pc", pc, 0); chk("ar_ir", ir_data, 0); chk("ar_ipc", inst_pc, 0); chk("ar_we", ir_we, 0);
    step();
    rst = 1;
    step();
    chk("ar2_ir", ir_data, 16'h1234); chk("ar2_ipc", inst_pc, 0); chk("ar2_pc", pc, 1);
    mem[12'hFFF] = 16'h0002;
    redirect_valid = 1; redirect_pc = 20'hFFFFF;
    step();
    redirect_valid = 0;
    step();
    chk("wr_ir", ir_data, 16'h0002); chk("wr_ipc", inst_pc, 20'hFFFFF); chk("wr_pc", pc, 0);
    mem[12'hFFF] = 16'h0003;
    redirect_valid = 1;
    step();
    redirect_valid = 0;
    step();
    chk("wr2a_pc", pc, 0); chk("wr2a_we", ir_we, 0);
    step();
    chk("wr2_ir", ir_data, 16'h0003); chk("wr2_imm", imm_data, 16'h1234);
    chk("wr2_ipc", inst_pc, 20'hFFFFF); chk("wr2_pc", pc, 1);
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(3) == 0);
      redirect_valid = ($urandom_range(9) == 0);
      redirect_pc = ($urandom_range(3) == 0) ? pc : 20'($urandom);
      step();
    end
    stall = 0; redirect_valid = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the 16-bit words loaded into the instruction register (IR) of the five-stage pipeline.
- Walks the program counter through instruction memory and assembles one- or two-word instructions. A two-word instruction is a 16-bit opcode word followed by a 16-bit immediate.
- Presents each complete instruction to the IR with a one-cycle write-enable pulse.
- Honours pipeline stall and branch/jump redirect requests.

Parameters:
- PC_WIDTH, 20, width of program counter and instruction memory address.
- RESET_PC, 0, PC value loaded on reset.
- IMM_BIT, 0, bit index of the opcode word that flags a trailing immediate word (1 = two-word instruction).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- stall  in  1  hold fetch; no PC advance, no IR write.
- redirect_valid  in  1  take redirect_pc next cycle; priority over stall.
- redirect_pc  in  PC_WIDTH  new fetch address.
- imem_addr  out  PC_WIDTH  instruction memory address, combinational, equals pc.
- imem_data  in  16  instruction memory read data, valid in the same cycle (asynchronous read).
- ir_we  out  1  registered; one-cycle pulse when ir_data/imm_data hold a new instruction.
- ir_data  out  16  registered opcode word for the IR.
- imm_data  out  16  registered immediate word; 0 for one-word instructions.
- imm_valid  out  1  registered; 1 when the current instruction carries imm_data.
- inst_pc  out  PC_WIDTH  registered address of the opcode word of the current instruction.
- pc  out  PC_WIDTH  current fetch address.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH. ir_we, ir_data, imm_data, imm_valid, inst_pc and the pending register are all cleared to 0. Reset mid two-word fetch discards the pending opcode.
- Per-cycle priority: redirect_valid, then stall, then normal operation.
- FETCH, redirect: pc<=redirect_pc, stay in FETCH, ir_we<=0. Output registers hold their values.
- FETCH, stall: pc and state hold, ir_we<=0, outputs hold.
- FETCH, imem_data[IMM_BIT]=0 (one-word):
  - ir_data<=imem_data, imm_data<=0, imm_valid<=0, inst_pc<=pc, ir_we<=1.
  - pc<=pc+1, stay in FETCH.
- FETCH, imem_data[IMM_BIT]=1 (two-word):
  - pending<=imem_data, pending_pc<=pc, pc<=pc+1.
  - state<=FETCH_IMM, ir_we<=0.
- FETCH_IMM, redirect: pending dropped, pc<=redirect_pc, state<=FETCH, ir_we<=0.
- FETCH_IMM, stall: everything holds, ir_we<=0.
- FETCH_IMM, normal:
  - ir_data<=pending, imm_data<=imem_data, imm_valid<=1, inst_pc<=pending_pc, ir_we<=1.
  - pc<=pc+1, state<=FETCH. The immediate word is never tested for IMM_BIT.
- Latency:
  - One-word instruction: ir_we rises at the clock edge after the word is addressed; one instruction per cycle sustained.
  - Two-word instruction: two cycles per instruction; ir_we high for one cycle only.
- ir_we is never high for two consecutive cycles with the same instruction. While stall=1, ir_we=0 and ir_data keeps the last instruction.
- PC arithmetic is modulo 2^PC_WIDTH: all-ones + 1 wraps to 0, including between the opcode and immediate words.
- Redirect during stall: redirect wins, and the stall is ignored for that cycle.
- Redirect to the current pc is legal; it behaves as a one-cycle bubble.
- The reset value of ir_data, 0, must decode as NOP downstream. ir_we stays 0 until the first real fetch completes.

Test Plan:
- Reset then release: rst=0 for 2 cycles, RESET_PC=0 → pc=0, ir_we=0, ir_data=0. Release with mem[0]=16'h1234 (bit0=0) → next edge ir_we=1, ir_data=16'h1234, imm_valid=0, inst_pc=0, pc=1.
- Two-word: mem[1]=16'h4321 (bit0=1), mem[2]=16'h270F → edge 1: ir_we=0, pc=2. Edge 2: ir_we=1, ir_data=16'h4321, imm_data=16'h270F, imm_valid=1, inst_pc=1, pc=3.
- Stall: stall=1 for 3 cycles during FETCH_IMM → pc, state and ir_data unchanged, ir_we=0 throughout. After release, one ir_we pulse with the correct opcode/immediate pair.
- Redirect: redirect_valid=1, redirect_pc=20'h00100, stall=1 in FETCH_IMM → pending dropped, pc=20'h00100, ir_we=0. The next instruction comes from mem[0x100].
- Async reset mid-operation: drive rst=0 between clock edges during FETCH_IMM → outputs clear immediately without a clock edge. After release, fetch restarts at RESET_PC.
- Wrap: PC_WIDTH=4, pc=15 with a one-word instruction → inst_pc=15, pc wraps to 0.
